// File: rtl/ysyx_22040386_pipe_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline with the dmem handshake FSM and a timeout watchdog.
// Optional macro PIPE_CTRL_PERF_CNT_EN adds memstall/load-use/flush event counters.
module ysyx_22040386_pipe_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 8
) (
  input  logic       i_PIPE_CTRL_clk,
  input  logic       i_PIPE_CTRL_rst_n,
  input  logic       i_PIPE_CTRL_jump_flag,
  input  logic       i_PIPE_CTRL_ID_EX_MemRead,
  input  logic [4:0] i_PIPE_CTRL_ID_EX_rd,
  input  logic [4:0] i_PIPE_CTRL_IF_ID_rs1,
  input  logic [4:0] i_PIPE_CTRL_IF_ID_rs2,
  input  logic       i_PIPE_CTRL_EX_MEM_MemRead,
  input  logic       i_PIPE_CTRL_EX_MEM_MemWrite,
  input  logic       i_PIPE_CTRL_dmem_ready,
  output logic       o_PIPE_CTRL_dmem_req,
  output logic       o_PIPE_CTRL_pc_wen,
  output logic       o_PIPE_CTRL_IF_ID_stall,
  output logic       o_PIPE_CTRL_IF_ID_flush,
  output logic       o_PIPE_CTRL_ID_EX_stall,
  output logic       o_PIPE_CTRL_ID_EX_flush,
  output logic       o_PIPE_CTRL_EX_MEM_stall,
  output logic       o_PIPE_CTRL_EX_MEM_flush,
  output logic       o_PIPE_CTRL_MEM_WB_flush,
  output logic       o_PIPE_CTRL_mem_err,
  output logic       o_PIPE_CTRL_busy
`ifdef PIPE_CTRL_PERF_CNT_EN
  ,
  output logic [31:0] o_PIPE_CTRL_memstall_cnt,
  output logic [31:0] o_PIPE_CTRL_loaduse_cnt,
  output logic [31:0] o_PIPE_CTRL_flush_cnt
`endif
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] ERR  = 2'd2;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  logic [1:0]       state;
  logic [1:0]       next_state;
  logic [CNT_W-1:0] wait_cnt;
  logic [CNT_W-1:0] next_cnt;
  logic             err_flag;

  logic memop;
  logic memstall;
  logic dmem_req;
  logic load_use;
  logic do_jump;
  logic do_load_use;

  // Load-use: a load in EX writes a nonzero register that ID is about to read.
  function automatic logic hazard_detect(input logic       mem_read,
                                         input logic [4:0] rd,
                                         input logic [4:0] rs1,
                                         input logic [4:0] rs2);
    return mem_read && (rd != 5'd0) && ((rd == rs1) || (rd == rs2));
  endfunction

  assign memop    = i_PIPE_CTRL_EX_MEM_MemRead | i_PIPE_CTRL_EX_MEM_MemWrite;
  assign load_use = hazard_detect(i_PIPE_CTRL_ID_EX_MemRead, i_PIPE_CTRL_ID_EX_rd,
                                  i_PIPE_CTRL_IF_ID_rs1, i_PIPE_CTRL_IF_ID_rs2);

  // Handshake FSM next-state, wait counter and per-state request/stall.
  always_comb begin
    next_state = state;
    next_cnt   = wait_cnt;
    dmem_req   = 1'b0;
    memstall   = 1'b0;
    case (state)
      IDLE: begin
        dmem_req = memop;
        next_cnt = CNT_ZERO;
        if (memop && !i_PIPE_CTRL_dmem_ready) begin
          memstall   = 1'b1;
          next_state = WAIT;
        end else begin
          memstall   = 1'b0;
          next_state = IDLE;
        end
      end
      WAIT: begin
        dmem_req = 1'b1;
        if (i_PIPE_CTRL_dmem_ready) begin
          memstall   = 1'b0;
          next_state = IDLE;
          next_cnt   = CNT_ZERO;
        end else if (wait_cnt == CNT_LAST) begin
          memstall   = 1'b1;
          next_state = ERR;
          next_cnt   = CNT_ZERO;
        end else begin
          memstall   = 1'b1;
          next_state = WAIT;
          next_cnt   = wait_cnt + CNT_ONE;
        end
      end
      ERR: begin
        // Terminal until reset: the pipeline stays frozen and the request is withdrawn.
        dmem_req   = 1'b0;
        memstall   = 1'b1;
        next_state = ERR;
        next_cnt   = CNT_ZERO;
      end
      default: begin
        dmem_req   = 1'b0;
        memstall   = 1'b1;
        next_state = IDLE;
        next_cnt   = CNT_ZERO;
      end
    endcase
  end

  // State, wait counter and sticky error flag.
  always_ff @(posedge i_PIPE_CTRL_clk or negedge i_PIPE_CTRL_rst_n) begin
    if (!i_PIPE_CTRL_rst_n) begin
      state    <= IDLE;
      wait_cnt <= CNT_ZERO;
      err_flag <= 1'b0;
    end else begin
      state    <= next_state;
      wait_cnt <= next_cnt;
      err_flag <= err_flag | (next_state == ERR);
    end
  end

  assign do_jump     = !memstall && i_PIPE_CTRL_jump_flag;
  assign do_load_use = !memstall && !i_PIPE_CTRL_jump_flag && load_use;

  // Pipeline controls by priority memstall > jump > load-use; all forced low in reset.
  always_comb begin
    o_PIPE_CTRL_dmem_req     = 1'b0;
    o_PIPE_CTRL_pc_wen       = 1'b0;
    o_PIPE_CTRL_IF_ID_stall  = 1'b0;
    o_PIPE_CTRL_IF_ID_flush  = 1'b0;
    o_PIPE_CTRL_ID_EX_stall  = 1'b0;
    o_PIPE_CTRL_ID_EX_flush  = 1'b0;
    o_PIPE_CTRL_EX_MEM_stall = 1'b0;
    o_PIPE_CTRL_EX_MEM_flush = 1'b0;
    o_PIPE_CTRL_MEM_WB_flush = 1'b0;
    o_PIPE_CTRL_mem_err      = 1'b0;
    o_PIPE_CTRL_busy         = 1'b0;
    if (!i_PIPE_CTRL_rst_n) begin
      o_PIPE_CTRL_pc_wen = 1'b0;
    end else begin
      o_PIPE_CTRL_dmem_req = dmem_req;
      o_PIPE_CTRL_mem_err  = err_flag;
      o_PIPE_CTRL_busy     = (state != IDLE);
      if (memstall) begin
        o_PIPE_CTRL_pc_wen       = 1'b0;
        o_PIPE_CTRL_IF_ID_stall  = 1'b1;
        o_PIPE_CTRL_ID_EX_stall  = 1'b1;
        o_PIPE_CTRL_EX_MEM_stall = 1'b1;
        o_PIPE_CTRL_MEM_WB_flush = 1'b1;
      end else if (do_jump) begin
        o_PIPE_CTRL_pc_wen       = 1'b1;
        o_PIPE_CTRL_IF_ID_flush  = 1'b1;
        o_PIPE_CTRL_ID_EX_flush  = 1'b1;
        o_PIPE_CTRL_EX_MEM_flush = 1'b1;
      end else if (do_load_use) begin
        o_PIPE_CTRL_pc_wen      = 1'b0;
        o_PIPE_CTRL_IF_ID_stall = 1'b1;
        o_PIPE_CTRL_ID_EX_flush = 1'b1;
      end else begin
        o_PIPE_CTRL_pc_wen = 1'b1;
      end
    end
  end

`ifdef PIPE_CTRL_PERF_CNT_EN
  // Event counters, one per effective (post-priority) condition, wrapping at 2^32.
  always_ff @(posedge i_PIPE_CTRL_clk or negedge i_PIPE_CTRL_rst_n) begin
    if (!i_PIPE_CTRL_rst_n) begin
      o_PIPE_CTRL_memstall_cnt <= 32'd0;
      o_PIPE_CTRL_loaduse_cnt  <= 32'd0;
      o_PIPE_CTRL_flush_cnt    <= 32'd0;
    end else begin
      if (memstall) begin
        o_PIPE_CTRL_memstall_cnt <= o_PIPE_CTRL_memstall_cnt + 32'd1;
      end else begin
        o_PIPE_CTRL_memstall_cnt <= o_PIPE_CTRL_memstall_cnt;
      end
      if (do_load_use) begin
        o_PIPE_CTRL_loaduse_cnt <= o_PIPE_CTRL_loaduse_cnt + 32'd1;
      end else begin
        o_PIPE_CTRL_loaduse_cnt <= o_PIPE_CTRL_loaduse_cnt;
      end
      if (do_jump) begin
        o_PIPE_CTRL_flush_cnt <= o_PIPE_CTRL_flush_cnt + 32'd1;
      end else begin
        o_PIPE_CTRL_flush_cnt <= o_PIPE_CTRL_flush_cnt;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ysyx_22040386_pipe_ctrl.sv
// Directed-vector bench for ysyx_22040386_pipe_ctrl (MEM_TIMEOUT = 4); outputs are packed
// as {dmem_req, pc_wen, IF_ID_stall, IF_ID_flush, ID_EX_stall, ID_EX_flush, EX_MEM_stall, EX_MEM_flush, MEM_WB_flush, mem_err, busy}.
module tb_ysyx_22040386_pipe_ctrl;

  logic       clk;
  logic       rst_n;
  logic       jump_flag;
  logic       id_ex_memread;
  logic [4:0] id_ex_rd;
  logic [4:0] if_id_rs1;
  logic [4:0] if_id_rs2;
  logic       ex_mem_memread;
  logic       ex_mem_memwrite;
  logic       dmem_ready;
  logic       dmem_req, pc_wen, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
  logic       ex_mem_stall, ex_mem_flush, mem_wb_flush, mem_err, busy;
`ifdef PIPE_CTRL_PERF_CNT_EN
  logic [31:0] memstall_cnt, loaduse_cnt, flush_cnt;
`endif

  int vec_cnt;
  int err_cnt;

  ysyx_22040386_pipe_ctrl #(.MEM_TIMEOUT(4), .CNT_W(8)) dut (
    .i_PIPE_CTRL_clk            (clk),
    .i_PIPE_CTRL_rst_n          (rst_n),
    .i_PIPE_CTRL_jump_flag      (jump_flag),
    .i_PIPE_CTRL_ID_EX_MemRead  (id_ex_memread),
    .i_PIPE_CTRL_ID_EX_rd       (id_ex_rd),
    .i_PIPE_CTRL_IF_ID_rs1      (if_id_rs1),
    .i_PIPE_CTRL_IF_ID_rs2      (if_id_rs2),
    .i_PIPE_CTRL_EX_MEM_MemRead (ex_mem_memread),
    .i_PIPE_CTRL_EX_MEM_MemWrite(ex_mem_memwrite),
    .i_PIPE_CTRL_dmem_ready     (dmem_ready),
    .o_PIPE_CTRL_dmem_req       (dmem_req),
    .o_PIPE_CTRL_pc_wen         (pc_wen),
    .o_PIPE_CTRL_IF_ID_stall    (if_id_stall),
    .o_PIPE_CTRL_IF_ID_flush    (if_id_flush),
    .o_PIPE_CTRL_ID_EX_stall    (id_ex_stall),
    .o_PIPE_CTRL_ID_EX_flush    (id_ex_flush),
    .o_PIPE_CTRL_EX_MEM_stall   (ex_mem_stall),
    .o_PIPE_CTRL_EX_MEM_flush   (ex_mem_flush),
    .o_PIPE_CTRL_MEM_WB_flush   (mem_wb_flush),
    .o_PIPE_CTRL_mem_err        (mem_err),
    .o_PIPE_CTRL_busy           (busy)
`ifdef PIPE_CTRL_PERF_CNT_EN
    ,
    .o_PIPE_CTRL_memstall_cnt   (memstall_cnt),
    .o_PIPE_CTRL_loaduse_cnt    (loaduse_cnt),
    .o_PIPE_CTRL_flush_cnt      (flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [10:0] outs();
    return {dmem_req, pc_wen, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
            ex_mem_stall, ex_mem_flush, mem_wb_flush, mem_err, busy};
  endfunction

  task automatic chk_vec(input string tag, input logic [10:0] act, input logic [10:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %03h expected %03h", tag, act, exp);
    end
  endtask

  task automatic set_in(input logic mr, input logic mw, input logic rdy, input logic jf,
                        input logic idmr, input logic [4:0] rd, input logic [4:0] r1,
                        input logic [4:0] r2);
    ex_mem_memread  = mr;
    ex_mem_memwrite = mw;
    dmem_ready      = rdy;
    jump_flag       = jf;
    id_ex_memread   = idmr;
    id_ex_rd        = rd;
    if_id_rs1       = r1;
    if_id_rs2       = r2;
  endtask

  // Called at posedge+1 with inputs applied: check mid-cycle, then step to next posedge+1.
  task automatic cycle(input string tag, input logic [10:0] exp);
    @(negedge clk);
    chk_vec(tag, outs(), exp);
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_cnt = 0;
    err_cnt = 0;
    rst_n   = 1'b0;
    set_in(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd5, 5'd5, 5'd0);
    cycle("rst_hold0", 11'h000);
    cycle("rst_hold1", 11'h000);
    rst_n = 1'b1;
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    cycle("idle", 11'h200);

    set_in(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    cycle("zero_wait_load", 11'h600);

    set_in(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    cycle("store_c1", 11'h554);
    cycle("store_c2", 11'h555);
    cycle("store_c3", 11'h555);
    dmem_ready = 1'b1;
    cycle("store_ready", 11'h601);
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    cycle("store_idle", 11'h200);

    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 5'd3, 5'd5);
    cycle("loaduse_rs2", 11'h120);
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd5, 5'd3, 5'd5);
    cycle("loaduse_clear", 11'h200);
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd9);
    cycle("loaduse_rd0", 11'h200);
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 5'd7, 5'd2);
    cycle("loaduse_rs1", 11'h120);
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 5'd6, 5'd2);
    cycle("loaduse_nomatch", 11'h200);

    set_in(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0);
    cycle("jump", 11'h2A8);
    set_in(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd5, 5'd5, 5'd0);
    cycle("jump_over_loaduse", 11'h2A8);

    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 5'd5, 5'd0);
    cycle("stall_over_loaduse", 11'h554);
    dmem_ready = 1'b1;
    cycle("loaduse_after_stall", 11'h521);
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    cycle("idle2", 11'h200);

    set_in(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0);
    cycle("jwait_c1", 11'h554);
    cycle("jwait_c2", 11'h555);
    dmem_ready = 1'b1;
    cycle("jwait_release", 11'h6A9);
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    cycle("idle3", 11'h200);

    set_in(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    cycle("rwait_c1", 11'h554);
    cycle("rwait_c2", 11'h555);
    #2;
    rst_n = 1'b0;
    #1;
    chk_vec("async_rst_wait", outs(), 11'h000);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    cycle("idle_after_rst", 11'h200);

    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    cycle("to_c1", 11'h554);
    cycle("to_w0", 11'h555);
    cycle("to_w1", 11'h555);
    cycle("to_w2", 11'h555);
    cycle("to_w3", 11'h555);
    cycle("to_err", 11'h157);
    dmem_ready = 1'b1;
    cycle("err_ignores_ready", 11'h157);
    set_in(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0);
    cycle("err_sticky", 11'h157);
    #2;
    rst_n = 1'b0;
    #1;
    chk_vec("async_rst_err", outs(), 11'h000);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    cycle("idle_after_err", 11'h200);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/ysyx_22040386_pipe_ctrl.md
Name: ysyx_22040386_pipe_ctrl

Overview:
Central stall/flush sequencer for the 5-stage pipeline. It generates hold and bubble controls for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers from three sources:
- load-use hazards;
- EX-stage jump/branch redirect;
- a multi-cycle data-memory handshake driven from the MEM stage.
It owns the dmem request/ready FSM and a timeout watchdog.

Parameters:
MEM_TIMEOUT, 16, max WAIT cycles before declaring a memory error (2..255)
CNT_W, 8, width of the wait counter; must hold MEM_TIMEOUT

Ports:
i_PIPE_CTRL_clk  in  1  clock, all state on rising edge
i_PIPE_CTRL_rst_n  in  1  reset, asynchronous, active-low
i_PIPE_CTRL_jump_flag  in  1  EX-stage redirect (jal/jalr/taken branch)
i_PIPE_CTRL_ID_EX_MemRead  in  1  instruction in EX is a load
i_PIPE_CTRL_ID_EX_rd  in  5  destination of instruction in EX
i_PIPE_CTRL_IF_ID_rs1  in  5  source 1 of instruction in ID
i_PIPE_CTRL_IF_ID_rs2  in  5  source 2 of instruction in ID
i_PIPE_CTRL_EX_MEM_MemRead  in  1  MEM-stage load
i_PIPE_CTRL_EX_MEM_MemWrite  in  1  MEM-stage store
i_PIPE_CTRL_dmem_ready  in  1  data memory completes the current access this cycle
o_PIPE_CTRL_dmem_req  out  1  data memory request valid
o_PIPE_CTRL_pc_wen  out  1  PC update enable
o_PIPE_CTRL_IF_ID_stall  out  1  hold IF/ID
o_PIPE_CTRL_IF_ID_flush  out  1  zero IF/ID
o_PIPE_CTRL_ID_EX_stall  out  1  hold ID/EX
o_PIPE_CTRL_ID_EX_flush  out  1  insert bubble into ID/EX
o_PIPE_CTRL_EX_MEM_stall  out  1  hold EX/MEM
o_PIPE_CTRL_EX_MEM_flush  out  1  drives EX/MEM jump_flag (control fields to 0, Branch_type to 3'b010)
o_PIPE_CTRL_MEM_WB_flush  out  1  bubble into MEM/WB
o_PIPE_CTRL_mem_err  out  1  sticky timeout error
o_PIPE_CTRL_busy  out  1  FSM not IDLE

Behaviour:
- FSM states: IDLE, WAIT, ERR. Reset forces IDLE, wait counter 0, mem_err 0.
- While rst_n is low, every output is 0, including pc_wen.
- memop = EX_MEM_MemRead | EX_MEM_MemWrite.
- IDLE:
  - dmem_req = memop.
  - memop & ready: zero-wait access, no stall, stay IDLE.
  - memop & !ready: go to WAIT next edge and raise memstall in the same cycle.
- WAIT:
  - dmem_req = 1; memstall = 1; counter increments each cycle.
  - ready: memstall drops that cycle, go to IDLE, counter cleared.
  - counter == MEM_TIMEOUT-1 & !ready: go to ERR.
- ERR:
  - dmem_req = 0; memstall = 1 permanently; mem_err = 1.
  - Leaves ERR only via reset.
- memstall:
  - pc_wen = 0.
  - IF_ID, ID_EX and EX_MEM stall = 1.
  - MEM_WB_flush = 1.
  - All other flushes = 0, with jump and load-use suppressed.
- Jump (no memstall):
  - IF_ID_flush, ID_EX_flush and EX_MEM_flush = 1.
  - pc_wen = 1, loading the target.
  - Load-use is ignored.
- Load-use (no memstall, no jump):
  - Condition: ID_EX_MemRead & rd != 0 & (rd == rs1 | rd == rs2).
  - pc_wen = 0; IF_ID_stall = 1; ID_EX_flush = 1.
  - Exactly one bubble per hazard; the condition clears naturally the next cycle.
- Otherwise: pc_wen = 1; all stall/flush outputs = 0.
- Priority is memstall > jump > load-use. A jump held during memstall is applied in the first cycle after the stall releases. EX is frozen, so jump_flag stays asserted until then.
- Control outputs are combinational from the registered state plus current inputs; only the state, counter and mem_err are flops.
- busy = (state != IDLE).
- Reset asserted mid-WAIT: immediate return to IDLE and dmem_req drops asynchronously.

Optional Feature:
Macro PIPE_CTRL_PERF_CNT_EN.
- Defined:
  - Adds three 32-bit wrapping outputs: o_PIPE_CTRL_memstall_cnt, o_PIPE_CTRL_loaduse_cnt and o_PIPE_CTRL_flush_cnt.
  - Each increments once per cycle its condition is the one in effect after priority.
  - Cleared by reset.
- Undefined: the ports and counters are absent and the rest of the behaviour is identical.

Test Plan:
- Zero-wait load: MemRead = 1, ready = 1 in the same cycle -> dmem_req = 1, no stall, busy stays 0, pc_wen = 1.
- 3-cycle store: MemWrite = 1, ready low for 3 cycles then high -> stalls and MEM_WB_flush high for exactly 3 cycles, busy high for 3 cycles, IDLE after the ready edge.
- Load-use: ID_EX_MemRead = 1, rd = 5, rs2 = 5 -> one cycle of pc_wen = 0, IF_ID_stall = 1, ID_EX_flush = 1.
- Load-use check with rd = 0 and rs1 = 0 -> no stall.
- Jump during WAIT: jump_flag = 1 while ready = 0 for 2 cycles -> no flushes during the stall. In the first cycle after ready, IF_ID, ID_EX and EX_MEM flush = 1 and pc_wen = 1.
- Timeout: MEM_TIMEOUT = 4, ready held 0 -> ERR entered after 4 WAIT cycles, mem_err = 1, dmem_req = 0. Asynchronous reset pulse -> all outputs 0 and IDLE.
